// File: rtl/latch_write_scheduler.sv
// latch_write_scheduler
// Arbitrates four write requesters round-robin and sequences each winning
// write into a bank of four level-sensitive latch entries. Every write goes
// through the same sequence: one SETUP cycle with the data bus settled and
// all enables low, EN_CYCLES cycles with exactly one enable high, and one
// HOLD cycle with the enable low again and the data bus still stable. Only
// in the HOLD cycle is the requester's grant pulsed. The data bus is
// therefore stable for a full cycle on both sides of every enable pulse.

module latch_write_scheduler #(
  parameter int WIDTH     = 8,
  parameter int EN_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [7:0]         addr,
  input  logic [4*WIDTH-1:0] data,
  output logic [3:0]         gnt,
  output logic               busy,
  output logic [WIDTH-1:0]   latch_d,
  output logic [3:0]         latch_en
);

  // A zero enable length would give no enable pulse at all, so it is
  // stretched to one cycle.
  localparam int             EN_EFF  = (EN_CYCLES < 1) ? 1 : EN_CYCLES;
  localparam logic [3:0]     EN_LAST = 4'(EN_EFF - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t     state;
  logic [1:0] ptr;       // index of the last winner; search starts after it
  logic [3:0] en_cnt;    // enable cycles remaining after the current one
  logic [1:0] cap_addr;  // latch entry targeted by the write in progress

  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] sel_addr;
  logic [WIDTH-1:0] sel_data;

  // Decode a 2-bit entry or requester index into a one-hot vector.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

  // Round-robin search: requester ptr+1 first, then onward, wrapping 3 -> 0,
  // with the last winner itself considered last.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    logic [1:0] cand;
    win_found = 1'b0;
    win_idx   = ptr;
    cand      = ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Slice out the winner's target entry and write data.
  always_comb begin
    sel_addr = addr[{win_idx, 1'b0} +: 2];
    sel_data = data[int'(win_idx)*WIDTH +: WIDTH];
  end

  // Captured target address; only read after it has been written on the
  // IDLE->SETUP transition, so it carries no reset.
  always_ff @(posedge clk) begin
    // NOTE: pure datapath capture registers that are always written before
    // being read are left without reset; only control state is reset.
    if (state == IDLE && win_found) begin
      cap_addr <= sel_addr;
    end
  end

  // Sequencing FSM with all outputs registered; reset wins over everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // in this block sees the pre-edge values of the others.
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd3;
      en_cnt   <= 4'd0;
      latch_en <= 4'b0000;
      gnt      <= 4'b0000;
      busy     <= 1'b0;
      latch_d  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // With no request every output simply holds its value.
          if (win_found) begin
            ptr     <= win_idx;
            latch_d <= sel_data;
            busy    <= 1'b1;
            state   <= SETUP;
          end
        end

        SETUP: begin
          // Data has settled for a cycle; open the one target entry.
          latch_en <= onehot4(cap_addr);
          en_cnt   <= EN_LAST;
          state    <= ENABLE;
        end

        ENABLE: begin
          if (en_cnt == 4'd0) begin
            latch_en <= 4'b0000;
            gnt      <= onehot4(ptr);
            state    <= HOLD;
          end else begin
            en_cnt <= en_cnt - 4'd1;
          end
        end

        HOLD: begin
          // Enable is closed and data still held; grant retires here.
          gnt   <= 4'b0000;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          latch_en <= 4'b0000;
          gnt      <= 4'b0000;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Structural invariants of the output protocol.
  a_en_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(latch_en));
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt));
  a_busy_state : assert property (@(posedge clk) disable iff (!rst_n)
    busy == (state != IDLE));
  a_d_stable : assert property (@(posedge clk)
    (rst_n && latch_en != 4'b0000) |=> (!rst_n || latch_d == $past(latch_d)));

endmodule

// File: tb/tb_latch_write_scheduler.sv
// Bench for latch_write_scheduler: directed stimulus pushes expected grants
// into a queue; a monitor pops and compares whenever a grant appears, and
// checks the bus invariants every cycle.

module tb_latch_write_scheduler;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst_n;
  logic [3:0]         req;
  logic [7:0]         addr;
  logic [4*WIDTH-1:0] data;
  logic [3:0]         gnt;
  logic               busy;
  logic [WIDTH-1:0]   latch_d;
  logic [3:0]         latch_en;

  latch_write_scheduler #(.WIDTH(WIDTH), .EN_CYCLES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .addr     (addr),
    .data     (data),
    .gnt      (gnt),
    .busy     (busy),
    .latch_d  (latch_d),
    .latch_en (latch_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       gnt;
    logic [WIDTH-1:0] d;
    logic [3:0]       en;
    int               en_len;
    int               gap;     // required cycles since previous grant, 0 = any
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req_val);
    n_checks++;
    if (act !== req_val) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, req_val);
    end
  endtask

  task automatic push_exp(input logic [3:0] g, input logic [WIDTH-1:0] d,
                          input logic [3:0] en, input int gap);
    exp_t e;
    e.gnt = g; e.d = d; e.en = en; e.en_len = 2; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Reset sampled at the last rising edge, read by the monitor at negedge.
  logic rst_edge = 1'b1;
  always @(posedge clk) rst_edge <= !rst_n;

  // Monitor: invariants each cycle, scoreboard compare on every grant.
  int               cyc = 0;
  int               last_gnt_cyc = 0;
  int               en_len_seen = 0;
  logic [3:0]       en_seen = '0;
  logic [3:0]       prev_en = '0;
  logic [WIDTH-1:0] prev_d = '0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_edge) begin
      en_len_seen = 0;
      en_seen     = '0;
    end else begin
      check("onehot0_latch_en", 32'($onehot0(latch_en)), 1);
      check("onehot0_gnt", 32'($onehot0(gnt)), 1);
      if (prev_en != 4'b0000) check("latch_d_stable", latch_d, prev_d);
      if (latch_en != 4'b0000) begin
        en_len_seen++;
        en_seen = latch_en;
      end
      if (gnt != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("gnt_unexpected", gnt, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_gnt", gnt, e.gnt);
          check("sb_latch_d", latch_d, e.d);
          check("sb_latch_en", en_seen, e.en);
          check("sb_en_len", en_len_seen, e.en_len);
          if (e.gap != 0) check("sb_gnt_gap", cyc - last_gnt_cyc, e.gap);
        end
        last_gnt_cyc = cyc;
        en_len_seen  = 0;
        en_seen      = '0;
      end
    end
    prev_en = rst_edge ? 4'b0000 : latch_en;
    prev_d  = latch_d;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    addr  = 8'h00;
    data  = '0;
    repeat (3) @(negedge clk);
    check("rst_latch_en", latch_en, 4'b0000);
    check("rst_gnt", gnt, 4'b0000);
    check("rst_busy", busy, 0);
    check("rst_latch_d", latch_d, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_req_busy", busy, 0);

    // Single write: requester 0 to entry 2 with A5; cycle-exact latency.
    req  = 4'b0001;
    addr = 8'b00_00_00_10;
    data = {24'h0, 8'hA5};
    push_exp(4'b0001, 8'hA5, 4'b0100, 0);
    @(negedge clk);                                   // SETUP
    check("t1_setup_busy", busy, 1);
    check("t1_setup_en", latch_en, 4'b0000);
    check("t1_setup_d", latch_d, 8'hA5);
    check("t1_setup_gnt", gnt, 4'b0000);
    req = 4'b0000;
    @(negedge clk);                                   // ENABLE 1
    check("t1_en1", latch_en, 4'b0100);
    @(negedge clk);                                   // ENABLE 2
    check("t1_en2", latch_en, 4'b0100);
    check("t1_en2_gnt", gnt, 4'b0000);
    @(negedge clk);                                   // HOLD
    check("t1_hold_en", latch_en, 4'b0000);
    check("t1_hold_gnt", gnt, 4'b0001);
    check("t1_hold_d", latch_d, 8'hA5);
    check("t1_hold_busy", busy, 1);
    @(negedge clk);                                   // IDLE
    check("t1_idle_gnt", gnt, 4'b0000);
    check("t1_idle_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("t1_idle_d_held", latch_d, 8'hA5);

    // Contention straight after reset: order 0,1,2,3,0 at 5-cycle spacing.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req  = 4'b1111;
    addr = 8'b11_10_01_00;
    data = {8'h13, 8'h12, 8'h11, 8'h10};
    push_exp(4'b0001, 8'h10, 4'b0001, 0);
    push_exp(4'b0010, 8'h11, 4'b0010, 5);
    push_exp(4'b0100, 8'h12, 4'b0100, 5);
    push_exp(4'b1000, 8'h13, 4'b1000, 5);
    push_exp(4'b0001, 8'h10, 4'b0001, 5);
    repeat (21) @(negedge clk);
    req = 4'b0000;
    repeat (8) @(negedge clk);

    // Fairness: last winner was 0, so requester 2 wins first, then alternate.
    req = 4'b0101;
    push_exp(4'b0100, 8'h12, 4'b0100, 0);
    push_exp(4'b0001, 8'h10, 4'b0001, 5);
    push_exp(4'b0100, 8'h12, 4'b0100, 5);
    push_exp(4'b0001, 8'h10, 4'b0001, 5);
    repeat (16) @(negedge clk);
    req = 4'b0000;
    repeat (8) @(negedge clk);

    // Inputs change mid-sequence: captured 3C must survive, grant still issued.
    req  = 4'b0001;
    addr = 8'b00_00_00_01;
    data = {24'h0, 8'h3C};
    push_exp(4'b0001, 8'h3C, 4'b0010, 0);
    @(negedge clk);                                   // SETUP
    @(negedge clk);                                   // ENABLE 1
    check("t4_en", latch_en, 4'b0010);
    data = {24'h0, 8'hFF};
    req  = 4'b0000;
    @(negedge clk);
    check("t4_d_kept", latch_d, 8'h3C);
    repeat (4) @(negedge clk);

    // Reset during ENABLE aborts with no grant; requester 3 served after.
    req  = 4'b0010;
    addr = 8'b00_00_11_00;
    data = {16'h0, 8'h5A, 8'h00};
    @(negedge clk);                                   // SETUP
    req = 4'b0000;
    @(negedge clk);                                   // ENABLE 1
    check("t5_en_before_rst", latch_en, 4'b1000);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_en", latch_en, 4'b0000);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_d", latch_d, 8'h00);
    check("t5_rst_gnt", gnt, 4'b0000);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    req  = 4'b1000;
    addr = 8'b00_00_00_00;
    data = {8'hC3, 24'h0};
    push_exp(4'b1000, 8'hC3, 4'b0001, 0);
    @(negedge clk);
    req = 4'b0000;
    repeat (8) @(negedge clk);

    check("sb_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
